// File: rtl/nn_param_pkg.sv
// rtl/nn_param_pkg.sv - shared mode encodings, default sizes and sizing helpers
package nn_param_pkg;

  localparam logic [1:0] MODE_HOLD   = 2'b00;
  localparam logic [1:0] MODE_SHIFT  = 2'b01;
  localparam logic [1:0] MODE_COMMIT = 2'b10;
  localparam logic [1:0] MODE_CLEAR  = 2'b11;

  localparam int DEF_N_NEURONS = 4;
  localparam int DEF_N_INPUTS  = 4;
  localparam int DEF_DATA_W    = 8;

  // Each neuron contributes N_INPUTS weights followed by one bias.
  function automatic int calc_depth(input int n_neurons, input int n_inputs);
    return n_neurons * (n_inputs + 1);
  endfunction

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/param_shift_chain.sv
// rtl/param_shift_chain.sv - DEPTH x DATA_W staging shift chain with clear and flat image output
module param_shift_chain #(
  parameter int DEPTH  = 20,
  parameter int DATA_W = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    shift_en,
  input  logic                    clear,
  input  logic [DATA_W-1:0]       data_in,
  output logic [DATA_W-1:0]       data_out,
  output logic [DEPTH*DATA_W-1:0] image
);

  logic [DEPTH*DATA_W-1:0] stage_q, stage_d;

  // Position p lives at bits [p*DATA_W +: DATA_W]; new words enter at the top.
  always_comb begin
    stage_d = stage_q;
    if (clear) begin
      stage_d = '0;
    end else if (shift_en) begin
      stage_d = {data_in, stage_q[DEPTH*DATA_W-1:DATA_W]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign image    = stage_q;
  assign data_out = stage_q[DATA_W-1:0];

endmodule

// File: rtl/param_shift_bank.sv
// rtl/param_shift_bank.sv - double-buffered serial parameter bank with load/commit control
module param_shift_bank
  import nn_param_pkg::*;
#(
  parameter int N_NEURONS = DEF_N_NEURONS,
  parameter int N_INPUTS  = DEF_N_INPUTS,
  parameter int DATA_W    = DEF_DATA_W
) (
  input  logic                                                 clk,
  input  logic                                                 reset,
  input  logic [DATA_W-1:0]                                    data_in,
  input  logic                                                 data_valid,
  input  logic [1:0]                                           mode,
  output logic [N_NEURONS*N_INPUTS*DATA_W-1:0]                 weights,
  output logic [N_NEURONS*DATA_W-1:0]                          biases,
  output logic [DATA_W-1:0]                                    data_out,
  output logic [cnt_width(calc_depth(N_NEURONS, N_INPUTS))-1:0] word_cnt,
  output logic                                                 load_done,
  output logic                                                 overflow,
  output logic                                                 param_valid,
  output logic                                                 commit_err
);

  localparam int DEPTH = calc_depth(N_NEURONS, N_INPUTS);
  localparam int CNT_W = cnt_width(DEPTH);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [DEPTH*DATA_W-1:0] image;
  logic [DEPTH*DATA_W-1:0] active_q;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    ovf_q, ovf_d;
  logic                    pv_q, pv_d;
  logic                    err_q, err_d;
  logic                    accept, commit_en, full;

  assign accept = (mode == MODE_SHIFT) && data_valid;
  assign full   = (cnt_q == CNT_FULL);

  param_shift_chain #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_chain (
    .clk      (clk),
    .reset    (reset),
    .shift_en (accept),
    .clear    (mode == MODE_CLEAR),
    .data_in  (data_in),
    .data_out (data_out),
    .image    (image)
  );

  always_comb begin
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    pv_d      = pv_q;
    err_d     = 1'b0;
    commit_en = 1'b0;
    case (mode)
      MODE_SHIFT: begin
        if (data_valid) begin
          if (full) ovf_d = 1'b1;
          else      cnt_d = cnt_q + CNT_W'(1);
        end
      end
      MODE_COMMIT: begin
        // Only a complete, uncorrupted image may replace the live parameters.
        if (full && !ovf_q) begin
          commit_en = 1'b1;
          pv_d      = 1'b1;
          cnt_d     = '0;
        end else begin
          err_d = 1'b1;
        end
      end
      MODE_CLEAR: begin
        cnt_d = '0;
        ovf_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      pv_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if (commit_en) active_q <= image;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      pv_q  <= pv_d;
      err_q <= err_d;
    end
  end

  // Unpack the staging order (weights then bias per neuron) into the two output buses.
  for (genvar n = 0; n < N_NEURONS; n++) begin : g_neuron
    for (genvar i = 0; i < N_INPUTS; i++) begin : g_weight
      assign weights[(n*N_INPUTS+i)*DATA_W +: DATA_W] =
        active_q[(n*(N_INPUTS+1)+i)*DATA_W +: DATA_W];
    end
    assign biases[n*DATA_W +: DATA_W] =
      active_q[(n*(N_INPUTS+1)+N_INPUTS)*DATA_W +: DATA_W];
  end

  assign word_cnt    = cnt_q;
  assign load_done   = full;
  assign overflow    = ovf_q;
  assign param_valid = pv_q;
  assign commit_err  = err_q;

endmodule
